// File: rtl/lr_pkg.sv
// Shared types and width helpers for the streaming line-fit block.
// Widths are derived so no intermediate can wrap.
package lr_pkg;

    typedef enum logic [2:0] {
        ST_ACC,
        ST_CALC_A,
        ST_CALC_B,
        ST_DIV1,
        ST_CALC0,
        ST_DIV0,
        ST_OUT
    } lr_state_t;

    localparam int SAT_W = 512;

    function automatic int lr_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    function automatic int lr_cnt_w(input int max_samples);
        return lr_clog2(max_samples + 1);
    endfunction

    function automatic int lr_acc_w(input int dw, input int max_samples);
        return 2 * dw + lr_cnt_w(max_samples);
    endfunction

    function automatic int lr_div_w(input int dw, input int fb,
                                    input int max_samples);
        return 2 * lr_acc_w(dw, max_samples) + fb + 2;
    endfunction

    // Clamp a wide signed value into a dw-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_fx(
        input logic signed [SAT_W-1:0] v,
        input int                      dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        for (int i = 0; i < SAT_W; i++) hi[i] = (i < dw - 1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/lr_serial_div.sv
// Signed restoring divider, one quotient bit per clock.
// Quotient is truncated toward zero; o_done pulses after WIDTH cycles.
module lr_serial_div #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             busy;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign a_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
    assign b_mag = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign trial = rem_sh - {1'b0, dsr};
    assign o_quotient = neg ? -quo : quo;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            quo    <= '0;
            rem    <= '0;
            dsr    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_start) begin
                quo  <= a_mag;
                rem  <= '0;
                dsr  <= b_mag;
                neg  <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
                cnt  <= CW'(WIDTH);
                busy <= 1'b1;
            end else if (busy) begin
                if (!trial[WIDTH]) begin
                    rem <= trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy   <= 1'b0;
                    o_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/linear_regression_stream_fx.sv
// Streaming least-squares fit z = theta0 + theta1*x on Q-format pairs.
// Accumulates sums, then solves with one shared serial divider.
module linear_regression_stream_fx
    import lr_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int MAX_SAMPLES = 1024
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_samples_x_in,
    input  logic [DATA_WIDTH-1:0] i_samples_z_in,
    input  logic                  i_samples_vld,
    input  logic                  i_samples_last,
    output logic                  o_samples_rdy,
    output logic [DATA_WIDTH-1:0] o_theta0_out,
    output logic [DATA_WIDTH-1:0] o_theta1_out,
    output logic                  o_theta_out_vld,
    input  logic                  i_theta_rdy,
    output logic                  o_err_degenerate,
    output logic                  o_err_overflow
);

    localparam int CNT_W  = lr_cnt_w(MAX_SAMPLES);
    localparam int ACC_W  = lr_acc_w(DATA_WIDTH, MAX_SAMPLES);
    localparam int DIV_W  = lr_div_w(DATA_WIDTH, FRAC_BITS, MAX_SAMPLES);
    localparam int PROD_W = 2 * ACC_W;
    localparam int XW     = 2 * DATA_WIDTH;
    localparam int TW     = DATA_WIDTH + ACC_W;

    lr_state_t state;

    logic        [CNT_W-1:0]      n;
    logic signed [ACC_W-1:0]      sx;
    logic signed [ACC_W-1:0]      sz;
    logic signed [ACC_W-1:0]      sxx;
    logic signed [ACC_W-1:0]      sxz;
    logic                         ovf;
    logic signed [PROD_W-1:0]     p_nsxz;
    logic signed [PROD_W-1:0]     p_sxsz;
    logic signed [PROD_W-1:0]     p_nsxx;
    logic signed [PROD_W-1:0]     p_sxsx;
    logic signed [DATA_WIDTH-1:0] theta1_q;

    logic signed [DATA_WIDTH-1:0] x_s;
    logic signed [DATA_WIDTH-1:0] z_s;
    logic signed [XW-1:0]         xx;
    logic signed [XW-1:0]         xz;
    logic signed [ACC_W-1:0]      n_s;
    logic signed [PROD_W-1:0]     n_p;
    logic signed [PROD_W-1:0]     sx_p;
    logic signed [PROD_W-1:0]     sz_p;
    logic signed [PROD_W-1:0]     sxx_p;
    logic signed [PROD_W-1:0]     sxz_p;
    logic signed [PROD_W-1:0]     diff1;
    logic signed [DIV_W-1:0]      num1;
    logic signed [DIV_W-1:0]      den;
    logic signed [TW-1:0]         t1sx;
    logic signed [DIV_W-1:0]      num0;
    logic                         degen;

    logic                         div_start;
    logic        [DIV_W-1:0]      div_a;
    logic        [DIV_W-1:0]      div_b;
    logic                         div_done;
    logic        [DIV_W-1:0]      div_quo;

    assign x_s = i_samples_x_in;
    assign z_s = i_samples_z_in;
    assign xx  = XW'(x_s) * XW'(x_s);
    assign xz  = XW'(x_s) * XW'(z_s);

    assign n_s   = $signed({{(ACC_W - CNT_W){1'b0}}, n});
    assign n_p   = PROD_W'(n_s);
    assign sx_p  = PROD_W'(sx);
    assign sz_p  = PROD_W'(sz);
    assign sxx_p = PROD_W'(sxx);
    assign sxz_p = PROD_W'(sxz);

    assign diff1 = p_nsxz - p_sxsz;
    assign num1  = DIV_W'(diff1) <<< FRAC_BITS;
    assign den   = DIV_W'(p_nsxx - p_sxsx);
    assign degen = (n < CNT_W'(2)) || (den == '0);

    assign t1sx = TW'(theta1_q) * TW'(sx);
    assign num0 = DIV_W'(sz) - DIV_W'(t1sx >>> FRAC_BITS);

    // One divider serves both the slope and the intercept divisions.
    assign div_start = ((state == ST_CALC_B) && !degen) ||
                       (state == ST_CALC0);
    assign div_a = (state == ST_CALC_B) ? num1 : num0;
    assign div_b = (state == ST_CALC_B) ? den : DIV_W'(n_s);

    assign o_samples_rdy = (state == ST_ACC);

    lr_serial_div #(
        .WIDTH(DIV_W)
    ) u_div (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_start    (div_start),
        .i_dividend (div_a),
        .i_divisor  (div_b),
        .o_done     (div_done),
        .o_quotient (div_quo)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= ST_ACC;
            n                <= '0;
            sx               <= '0;
            sz               <= '0;
            sxx              <= '0;
            sxz              <= '0;
            ovf              <= 1'b0;
            p_nsxz           <= '0;
            p_sxsz           <= '0;
            p_nsxx           <= '0;
            p_sxsx           <= '0;
            theta1_q         <= '0;
            o_theta0_out     <= '0;
            o_theta1_out     <= '0;
            o_theta_out_vld  <= 1'b0;
            o_err_degenerate <= 1'b0;
            o_err_overflow   <= 1'b0;
        end else begin
            unique case (state)
                ST_ACC: begin
                    if (i_samples_vld) begin
                        if (n < CNT_W'(MAX_SAMPLES)) begin
                            sx  <= sx + ACC_W'(x_s);
                            sz  <= sz + ACC_W'(z_s);
                            sxx <= sxx + ACC_W'(xx);
                            sxz <= sxz + ACC_W'(xz);
                            n   <= n + CNT_W'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                        if (i_samples_last) state <= ST_CALC_A;
                    end
                end
                ST_CALC_A: begin
                    p_nsxz <= n_p * sxz_p;
                    p_sxsz <= sx_p * sz_p;
                    p_nsxx <= n_p * sxx_p;
                    p_sxsx <= sx_p * sx_p;
                    state  <= ST_CALC_B;
                end
                ST_CALC_B: begin
                    state <= degen ? ST_OUT : ST_DIV1;
                end
                ST_DIV1: begin
                    if (div_done) begin
                        theta1_q <= DATA_WIDTH'(
                            sat_fx(SAT_W'($signed(div_quo)), DATA_WIDTH));
                        state <= ST_CALC0;
                    end
                end
                ST_CALC0: begin
                    state <= ST_DIV0;
                end
                ST_DIV0: begin
                    if (div_done) begin
                        o_theta0_out <= DATA_WIDTH'(
                            sat_fx(SAT_W'($signed(div_quo)), DATA_WIDTH));
                        o_theta1_out     <= theta1_q;
                        o_err_degenerate <= 1'b0;
                        o_err_overflow   <= ovf;
                        o_theta_out_vld  <= 1'b1;
                        state            <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    // A degenerate frame enters here without a result; latch it now.
                    if (!o_theta_out_vld) begin
                        o_theta0_out     <= '0;
                        o_theta1_out     <= '0;
                        o_err_degenerate <= 1'b1;
                        o_err_overflow   <= ovf;
                        o_theta_out_vld  <= 1'b1;
                    end else if (i_theta_rdy) begin
                        o_theta_out_vld  <= 1'b0;
                        o_err_degenerate <= 1'b0;
                        o_err_overflow   <= 1'b0;
                        n                <= '0;
                        sx               <= '0;
                        sz               <= '0;
                        sxx              <= '0;
                        sxz              <= '0;
                        ovf              <= 1'b0;
                        state            <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_regression_stream_fx.sv
// Directed bench for linear_regression_stream_fx.
// Table of frames plus hand sequences for hold, reset, overflow and saturation.
module tb_linear_regression_stream_fx;

    localparam int W_A   = 2 * (2 * 32 + $clog2(1025)) + 16 + 2;
    localparam int W_B   = 2 * (2 * 32 + $clog2(9)) + 16 + 2;
    localparam int LAT_A = 2 * W_A + 5;
    localparam int LAT_B = 2 * W_B + 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [31:0] a_x, a_z, a_t0, a_t1;
    logic        a_vld, a_last, a_rdy, a_ovld, a_trdy, a_deg, a_ovf;
    logic [31:0] b_x, b_z, b_t0, b_t1;
    logic        b_vld, b_last, b_rdy, b_ovld, b_trdy, b_deg, b_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] xbuf [16];
    logic [31:0] zbuf [16];

    typedef struct {
        int          n;
        longint      x0;
        longint      dx;
        longint      a;
        longint      b;
        logic [31:0] t0;
        logic [31:0] t1;
        logic        deg;
        int          lat;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    linear_regression_stream_fx dut_a (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_samples_x_in   (a_x),
        .i_samples_z_in   (a_z),
        .i_samples_vld    (a_vld),
        .i_samples_last   (a_last),
        .o_samples_rdy    (a_rdy),
        .o_theta0_out     (a_t0),
        .o_theta1_out     (a_t1),
        .o_theta_out_vld  (a_ovld),
        .i_theta_rdy      (a_trdy),
        .o_err_degenerate (a_deg),
        .o_err_overflow   (a_ovf)
    );

    linear_regression_stream_fx #(
        .MAX_SAMPLES(8)
    ) dut_b (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_samples_x_in   (b_x),
        .i_samples_z_in   (b_z),
        .i_samples_vld    (b_vld),
        .i_samples_last   (b_last),
        .o_samples_rdy    (b_rdy),
        .o_theta0_out     (b_t0),
        .o_theta1_out     (b_t1),
        .o_theta_out_vld  (b_ovld),
        .i_theta_rdy      (b_trdy),
        .o_err_degenerate (b_deg),
        .o_err_overflow   (b_ovf)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic [31:0] x,
                         input logic [31:0] z, input logic v,
                         input logic l);
        if (sel) begin
            b_x = x; b_z = z; b_vld = v; b_last = l;
        end else begin
            a_x = x; a_z = z; a_vld = v; a_last = l;
        end
    endtask

    function automatic logic get_rdy(input bit sel);
        return sel ? b_rdy : a_rdy;
    endfunction

    function automatic logic get_vld(input bit sel);
        return sel ? b_ovld : a_ovld;
    endfunction

    task automatic build(input longint x0, input longint dx,
                         input longint a, input longint b, input int n);
        longint x;
        for (int i = 0; i < n; i++) begin
            x = x0 + longint'(i) * dx;
            xbuf[i] = 32'(x);
            zbuf[i] = 32'(((a * x) >>> 16) + b);
        end
    endtask

    task automatic send_frame(input bit sel, input int n, input bit gaps,
                              input bit wait_res, output int lat);
        int g;
        int guard;
        lat = -1;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    @(negedge clk);
                    drive(sel, '0, '0, 1'b0, 1'b0);
                end
            end
            @(negedge clk);
            drive(sel, xbuf[i], zbuf[i], 1'b1, i == n - 1);
            guard = 0;
            while (!get_rdy(sel) && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 64) check("rdy_wait", 32'(get_rdy(sel)), 32'd1);
            @(posedge clk);
            #1;
            drive(sel, '0, '0, 1'b0, 1'b0);
        end
        if (wait_res) begin
            lat = 0;
            while (lat < 2000) begin
                @(posedge clk);
                #1;
                lat++;
                if (get_vld(sel)) break;
            end
        end
    endtask

    task automatic accept(input bit sel, input string name);
        @(negedge clk);
        if (sel) b_trdy = 1'b1; else a_trdy = 1'b1;
        @(posedge clk);
        #1;
        if (sel) b_trdy = 1'b0; else a_trdy = 1'b0;
        check({name, "_rdy_after"}, 32'(get_rdy(sel)), 32'd1);
        check({name, "_vld_after"}, 32'(get_vld(sel)), 32'd0);
    endtask

    task automatic check_a(input string name, input int lat,
                           input int exp_lat, input logic [31:0] t0,
                           input logic [31:0] t1, input logic deg);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_t0"}, a_t0, t0);
        check({name, "_t1"}, a_t1, t1);
        check({name, "_deg"}, 32'(a_deg), 32'(deg));
        check({name, "_ovf"}, 32'(a_ovf), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic ok;

        drive(0, '0, '0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0);
        a_trdy = 1'b0;
        b_trdy = 1'b0;

        vecs[0] = '{10, 0, 65536, 131072, 196608,
                    32'h00030000, 32'h00020000, 1'b0, LAT_A};
        vecs[1] = '{9, -262144, 65536, -32768, 65536,
                    32'h00010000, 32'hFFFF8000, 1'b0, LAT_A};
        vecs[2] = '{6, 327680, 0, 65536, 0,
                    32'h0, 32'h0, 1'b1, 3};
        vecs[3] = '{1, 131072, 65536, 65536, 65536,
                    32'h0, 32'h0, 1'b1, 3};
        vecs[4] = '{5, 65536, 131072, 16384, -131072,
                    32'hFFFE0000, 32'h00004000, 1'b0, LAT_A};
        vecs[5] = '{4, -196608, -98304, 196608, -32768,
                    32'hFFFF8000, 32'h00030000, 1'b0, LAT_A};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(a_rdy), 32'd1);
        check("rst_vld", 32'(a_ovld), 32'd0);
        check("rst_t0", a_t0, 32'd0);
        check("rst_t1", a_t1, 32'd0);
        check("rst_err", {30'd0, a_deg, a_ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            build(vecs[v].x0, vecs[v].dx, vecs[v].a, vecs[v].b, vecs[v].n);
            send_frame(0, vecs[v].n, 1'b0, 1'b1, lat);
            check_a($sformatf("vec%0d", v), lat, vecs[v].lat,
                    vecs[v].t0, vecs[v].t1, vecs[v].deg);
            accept(0, $sformatf("vec%0d", v));
        end

        xbuf[0] = 32'd0; zbuf[0] = 32'd0;
        xbuf[1] = 32'd1; zbuf[1] = 32'h00640000;
        send_frame(0, 2, 1'b0, 1'b1, lat);
        check_a("sat_pos", lat, LAT_A, 32'h0031C000, 32'h7FFFFFFF, 1'b0);
        accept(0, "sat_pos");
        zbuf[1] = 32'hFF9C0000;
        send_frame(0, 2, 1'b0, 1'b1, lat);
        check_a("sat_neg", lat, LAT_A, 32'hFFCE4000, 32'h80000000, 1'b0);
        accept(0, "sat_neg");

        for (int i = 0; i < 10; i++) begin
            xbuf[i] = 32'((i + 1) * 65536);
            zbuf[i] = 32'((i + 1) * 65536);
        end
        send_frame(1, 10, 1'b0, 1'b1, lat);
        check("ovf_lat", 32'(lat), 32'(LAT_B));
        check("ovf_flag", 32'(b_ovf), 32'd1);
        check("ovf_deg", 32'(b_deg), 32'd0);
        check("ovf_t1", b_t1, 32'h00010000);
        check("ovf_t0", b_t0, 32'h0);
        accept(1, "ovf");

        build(0, 65536, 131072, 196608, 10);
        send_frame(0, 10, 1'b0, 1'b1, lat);
        check_a("hold_pre", lat, LAT_A, 32'h00030000, 32'h00020000, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            drive(0, 32'h7FFF0000, 32'h12340000, 1'b1, 1'b1);
            ok = a_ovld && !a_rdy && (a_t0 == 32'h00030000) &&
                 (a_t1 == 32'h00020000) && !a_deg && !a_ovf;
            check($sformatf("hold_c%0d", c), 32'(ok), 32'd1);
        end
        accept(0, "hold");
        drive(0, '0, '0, 1'b0, 1'b0);

        send_frame(0, 10, 1'b0, 1'b0, lat);
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy", 32'(a_rdy), 32'd1);
        check("midrst_vld", 32'(a_ovld), 32'd0);
        check("midrst_t0", a_t0, 32'd0);
        check("midrst_t1", a_t1, 32'd0);
        check("midrst_err", {30'd0, a_deg, a_ovf}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(0, 10, 1'b0, 1'b1, lat);
        check_a("postrst", lat, LAT_A, 32'h00030000, 32'h00020000, 1'b0);
        accept(0, "postrst");

        build(-262144, 65536, -32768, 65536, 9);
        send_frame(0, 9, 1'b1, 1'b1, lat);
        check_a("gaps", lat, LAT_A, 32'h00010000, 32'hFFFF8000, 1'b0);
        accept(0, "gaps");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
